axi_wr_burst_sequencer: RTL and testbench
=========================================

Name: axi_wr_burst_sequencer

Overview:
Controls the AXI write path for the peripheral-to-AXI bridge. It pops burst descriptors from the burst FIFO, drives the AXI write-address (AW) channel, and starts the data packer once per burst. It then waits for the packer's last beat, tracks outstanding write responses (B channel) against a credit limit, and records response and protocol errors. The block sits between the burst FIFO, the data packer and the AXI slave port.

Parameters:
MAX_OUTSTANDING, 4, maximum bursts with AW accepted but B not yet received (1..15)
CNT_W, 4, width of outstanding counter; must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
b_empty  in  1  burst FIFO empty
burst_addr  in  32  burst start address from burst FIFO; valid the cycle after burst_pop
burst_info  in  12  [11:4] AXI len (beats-1), [3:0] log2 beat size; valid the cycle after burst_pop
burst_pop  out  1  one-cycle pop strobe to burst FIFO
axi_awvalid  out  1  AW valid
axi_awready  in  1  AW ready
axi_awaddr  out  32  AW address
axi_awlen  out  8  AW len
axi_awsize  out  3  AW size
axi_awburst  out  2  fixed 2'b01 (INCR)
pkr_start  out  1  one-cycle pulse: packer may begin the burst
w_last_hs  in  1  axi_wvalid & axi_wready & axi_wlast seen on W channel
axi_bvalid  in  1  B valid
axi_bresp  in  2  B response
axi_bready  out  1  B ready
outstanding  out  CNT_W  bursts awaiting B
busy  out  1  state != IDLE or outstanding != 0
err_sticky  out  3  [0] SLVERR/DECERR seen, [1] unexpected B, [2] illegal size
err_clr  in  1  synchronous clear of err_sticky (set events in the same cycle win)

Behaviour:
- Reset values: all outputs 0 except axi_awburst = 2'b01. State returns to IDLE. Reset mid-burst abandons the burst; no recovery.
- FSM has four states: IDLE, LOAD, ADDR, DATA.
- IDLE: if !b_empty and outstanding < MAX_OUTSTANDING, assert burst_pop for one cycle and go to LOAD. Otherwise stay in IDLE.
- LOAD: register burst_addr into axi_awaddr, burst_info[11:4] into axi_awlen, and burst_info[2:0] into axi_awsize. If burst_info[3:0] > 2, set err_sticky[2] but still issue the burst. Go to ADDR.
- ADDR: axi_awvalid = 1. awaddr/len/size are held stable until the handshake. On awvalid & awready:
  - drop awvalid the next cycle,
  - pulse pkr_start for 1 cycle,
  - increment outstanding,
  - go to DATA.
- DATA: wait for w_last_hs, then go to IDLE. w_last_hs in any other state is ignored.
- Minimum burst-to-burst spacing: the next burst_pop may occur the cycle after w_last_hs (back-to-back descriptors). AW of burst N+1 is never issued before W of burst N completes.
- B channel:
  - axi_bready = (outstanding != 0).
  - On bvalid & bready, decrement outstanding.
  - If bresp[1] = 1, set err_sticky[0].
  - If bvalid arrives while outstanding == 0, set err_sticky[1] and leave the counter unchanged.
- Simultaneous AW handshake and B handshake: outstanding is unchanged.
- Counter saturates: it never wraps below 0 or above MAX_OUTSTANDING.
- Credit full (outstanding == MAX_OUTSTANDING): IDLE stalls with burst_pop = 0 until a B handshake frees a credit. The pop may then occur the cycle after that handshake.
- pkr_start is only ever asserted the cycle after an AW handshake.

Decomposition:
- Shared package axi_bridge_pkg holds:
  - state encoding constants,
  - AXI_BURST_INCR = 2'b01,
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR,
  - burst_info field offsets (LEN_MSB=11, LEN_LSB=4, SIZE_MSB=3).
- One natural sub-module, axi_resp_credit_cnt: an up/down saturating counter with simultaneous-event handling, bready generation and unexpected-B detection. Reusable for a future read-side sequencer.

Test Plan:
- Single burst, addr 0x1000, info 0x032 (len 3, size 2), awready after 2 cycles -> one burst_pop; awaddr=0x1000, awlen=3, awsize=2 held over 3 cycles; pkr_start 1 cycle after handshake; outstanding=1; after w_last_hs and B OKAY, outstanding=0, busy=0.
- Credit limit: MAX_OUTSTANDING=2, 3 descriptors queued, B withheld -> exactly 2 AW handshakes; third burst_pop not asserted until first B handshake, then asserted the next cycle.
- Simultaneous AW handshake and B handshake with outstanding=1 -> outstanding stays 1.
- Error responses: B with bresp=2'b10 -> err_sticky[0]=1. bvalid with outstanding=0 -> err_sticky[1]=1, counter stays 0. err_clr -> err_sticky=0. err_clr in the same cycle as a new SLVERR -> err_sticky[0]=1.
- Illegal size: info 0x013 (size log2 3) -> err_sticky[2]=1, AW still issued with awsize=3.
- Reset mid-operation: assert rst_n=0 while in ADDR with awvalid high -> awvalid, burst_pop, pkr_start, outstanding all 0 immediately. After release, the next descriptor is processed normally from IDLE.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared encodings for the peripheral-to-AXI bridge: write FSM states, AXI constants,
// burst descriptor field offsets and the registered AW request.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int LEN_MSB  = 11;
  localparam int LEN_LSB  = 4;
  localparam int SIZE_MSB = 3;

  // Largest beat size the bridge supports: 4 bytes (log2 = 2).
  localparam logic [SIZE_MSB:0] MAX_SIZE_LOG2 = 4'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } aw_req_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_resp_credit_cnt.sv
// Saturating count of requests awaiting a response; accepts responses only while non-zero.
// Zero-latency ready; a simultaneous request and response leave the count unchanged.
module axi_resp_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             rsp_vld,
  output logic             rsp_rdy,
  output logic [CNT_W-1:0] cnt,
  output logic             credit_avail,
  output logic             unexp_rsp
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             dec;

  assign rsp_rdy      = (cnt_q != '0);
  assign dec          = rsp_vld & rsp_rdy;
  assign unexp_rsp    = rsp_vld & (cnt_q == '0);
  assign credit_avail = (cnt_q < MAX_CNT);
  assign cnt          = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && !dec && (cnt_q != MAX_CNT)) begin
      cnt_q <= cnt_q + ONE;
    end else if (dec && !inc) begin
      cnt_q <= cnt_q - ONE;
    end
  end

endmodule

// File: rtl/axi_wr_burst_sequencer.sv
// Pops burst descriptors, issues AXI AW, kicks the packer, and tracks B credits and errors.
// Pop to AWVALID takes 2 cycles; stalls on empty FIFO, full credits, AWREADY low and the W last beat.
module axi_wr_burst_sequencer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_empty,
  input  logic [31:0]      burst_addr,
  input  logic [11:0]      burst_info,
  output logic             burst_pop,
  output logic             axi_awvalid,
  input  logic             axi_awready,
  output logic [31:0]      axi_awaddr,
  output logic [7:0]       axi_awlen,
  output logic [2:0]       axi_awsize,
  output logic [1:0]       axi_awburst,
  output logic             pkr_start,
  input  logic             w_last_hs,
  input  logic             axi_bvalid,
  input  logic [1:0]       axi_bresp,
  output logic             axi_bready,
  output logic [CNT_W-1:0] outstanding,
  output logic             busy,
  output logic [2:0]       err_sticky,
  input  logic             err_clr
);

  import axi_bridge_pkg::*;

  wr_state_e state_q, state_d;
  aw_req_t   aw_q;
  logic      pkr_start_q;
  logic      armed_q;
  logic [2:0] err_q;
  logic      aw_hs, b_hs, credit_avail, unexp_b, size_bad;

  axi_resp_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_credit (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (aw_hs),
    .rsp_vld      (axi_bvalid),
    .rsp_rdy      (axi_bready),
    .cnt          (outstanding),
    .credit_avail (credit_avail),
    .unexp_rsp    (unexp_b)
  );

  assign axi_awvalid = (state_q == ST_ADDR);
  assign aw_hs       = axi_awvalid & axi_awready;
  assign b_hs        = axi_bvalid & axi_bready;
  assign size_bad    = (burst_info[SIZE_MSB:0] > MAX_SIZE_LOG2);

  // armed_q holds off the pop strobe until the first cycle after reset release.
  always_comb begin
    state_d   = state_q;
    burst_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !b_empty && credit_avail) begin
          burst_pop = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_ADDR;
      ST_ADDR: if (axi_awready) state_d = ST_DATA;
      ST_DATA: if (w_last_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aw_q        <= '0;
      pkr_start_q <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      pkr_start_q <= aw_hs;
      armed_q     <= 1'b1;
      if (state_q == ST_LOAD) begin
        aw_q.addr <= burst_addr;
        aw_q.len  <= burst_info[LEN_MSB:LEN_LSB];
        aw_q.size <= burst_info[SIZE_MSB-1:0];
      end
      // New error events override a same-cycle clear.
      err_q <= (err_clr ? 3'b000 : err_q)
             | {(state_q == ST_LOAD) && size_bad, unexp_b, b_hs && resp_is_err(axi_bresp)};
    end
  end

  assign axi_awaddr  = aw_q.addr;
  assign axi_awlen   = aw_q.len;
  assign axi_awsize  = aw_q.size;
  assign axi_awburst = AXI_BURST_INCR;
  assign pkr_start   = pkr_start_q;
  assign err_sticky  = err_q;
  assign busy        = (state_q != ST_IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_axi_wr_burst_sequencer.sv
// Directed bench for the AXI write burst sequencer with a two-credit limit.
module tb_axi_wr_burst_sequencer;

  localparam int MAX_OUT = 2;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             b_empty, burst_pop;
  logic [31:0]      burst_addr;
  logic [11:0]      burst_info;
  logic             axi_awvalid, axi_awready;
  logic [31:0]      axi_awaddr;
  logic [7:0]       axi_awlen;
  logic [2:0]       axi_awsize;
  logic [1:0]       axi_awburst;
  logic             pkr_start, w_last_hs;
  logic             axi_bvalid, axi_bready;
  logic [1:0]       axi_bresp;
  logic [CNT_W-1:0] outstanding;
  logic             busy, err_clr;
  logic [2:0]       err_sticky;

  always #5 clk = ~clk;

  axi_wr_burst_sequencer #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .b_empty     (b_empty),
    .burst_addr  (burst_addr),
    .burst_info  (burst_info),
    .burst_pop   (burst_pop),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .pkr_start   (pkr_start),
    .w_last_hs   (w_last_hs),
    .axi_bvalid  (axi_bvalid),
    .axi_bresp   (axi_bresp),
    .axi_bready  (axi_bready),
    .outstanding (outstanding),
    .busy        (busy),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [11:0] info;
  } desc_t;

  desc_t fq[$];
  desc_t fifo_ent;
  int n_chk = 0, n_fail = 0;
  int pop_cnt = 0, bad_pop = 0, aw_cnt = 0, pkr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Burst FIFO model: data appears the cycle after the pop strobe.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && burst_pop) begin
      if (fq.size() == 0) begin
        bad_pop++;
      end else begin
        pop_cnt++;
        fifo_ent = fq.pop_front();
        @(posedge clk);
        #1;
        burst_addr = fifo_ent.addr;
        burst_info = fifo_ent.info;
        b_empty    = (fq.size() == 0);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (pkr_start) pkr_cnt++;
    if (axi_awvalid && axi_awready) aw_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [11:0] i);
    fq.push_back('{addr: a, info: i});
    b_empty = 1'b0;
  endtask

  task automatic wait_aw(input string tag);
    int k = 0;
    while (!axi_awvalid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " awvalid"}, 32'(axi_awvalid), 32'd1);
  endtask

  task automatic b_resp(input logic [1:0] resp);
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    neg(1);
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [11:0] i);
    int k = 0;
    push(a, i);
    axi_awready = 1'b1;
    while (!pkr_start && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("run_burst pkr_start", 32'(pkr_start), 32'd1);
    axi_awready = 1'b0;
    w_last_hs   = 1'b1;
    neg(1);
    w_last_hs   = 1'b0;
  endtask

  initial begin
    b_empty = 1'b1; burst_addr = '0; burst_info = '0;
    axi_awready = 1'b0; w_last_hs = 1'b0;
    axi_bvalid = 1'b0; axi_bresp = 2'b00; err_clr = 1'b0;

    #3;
    check("rst burst_pop",   32'(burst_pop),   32'd0);
    check("rst awvalid",     32'(axi_awvalid), 32'd0);
    check("rst awburst",     32'(axi_awburst), 32'd1);
    check("rst pkr_start",   32'(pkr_start),   32'd0);
    check("rst outstanding", 32'(outstanding), 32'd0);
    check("rst busy",        32'(busy),        32'd0);
    check("rst err",         32'(err_sticky),  32'd0);
    check("rst bready",      32'(axi_bready),  32'd0);
    neg(2);
    rst_n = 1'b1;
    neg(1);

    // Single burst, AWREADY withheld for two cycles.
    push(32'h1000, 12'h032);
    wait_aw("t1");
    for (int i = 0; i < 3; i++) begin
      check("t1 awvalid held", 32'(axi_awvalid), 32'd1);
      check("t1 awaddr",       axi_awaddr,       32'h1000);
      check("t1 awlen",        32'(axi_awlen),   32'd3);
      check("t1 awsize",       32'(axi_awsize),  32'd2);
      if (i == 2) axi_awready = 1'b1;
      neg(1);
    end
    axi_awready = 1'b0;
    check("t1 awvalid drop",  32'(axi_awvalid), 32'd0);
    check("t1 pkr_start",     32'(pkr_start),   32'd1);
    check("t1 outstanding",   32'(outstanding), 32'd1);
    check("t1 pop count",     32'(pop_cnt),     32'd1);
    w_last_hs = 1'b1;
    neg(1);
    w_last_hs = 1'b0;
    check("t1 pkr one cycle", 32'(pkr_start),   32'd0);
    check("t1 busy waiting B", 32'(busy),       32'd1);
    b_resp(2'b00);
    check("t1 outstanding B", 32'(outstanding), 32'd0);
    check("t1 busy idle",     32'(busy),        32'd0);
    check("t1 err",           32'(err_sticky),  32'd0);

    // Credit limit: three descriptors, B withheld.
    push(32'h2000, 12'h012);
    push(32'h3000, 12'h012);
    push(32'h4000, 12'h012);
    axi_awready = 1'b1;
    w_last_hs   = 1'b1;
    neg(16);
    check("t2 aw count stalled",  32'(aw_cnt),      32'd3);
    check("t2 pop count stalled", 32'(pop_cnt),     32'd3);
    check("t2 outstanding full",  32'(outstanding), 32'd2);
    check("t2 pop held off",      32'(burst_pop),   32'd0);
    b_resp(2'b00);
    check("t2 pop after B",       32'(burst_pop),   32'd1);
    check("t2 outstanding freed", 32'(outstanding), 32'd1);
    neg(8);
    check("t2 aw count",          32'(aw_cnt),      32'd4);
    check("t2 outstanding refill", 32'(outstanding), 32'd2);
    axi_awready = 1'b0;
    w_last_hs   = 1'b0;

    // Simultaneous AW and B handshakes with one outstanding.
    b_resp(2'b00);
    check("t3 outstanding pre", 32'(outstanding), 32'd1);
    push(32'h5000, 12'h012);
    wait_aw("t3");
    axi_awready = 1'b1;
    axi_bvalid  = 1'b1;
    axi_bresp   = 2'b00;
    neg(1);
    axi_awready = 1'b0;
    axi_bvalid  = 1'b0;
    check("t3 outstanding same", 32'(outstanding), 32'd1);
    check("t3 pkr_start",        32'(pkr_start),   32'd1);
    w_last_hs = 1'b1;
    neg(1);
    w_last_hs = 1'b0;

    // Error responses and sticky clear.
    b_resp(2'b10);
    check("t4 slverr",          32'(err_sticky),  32'b001);
    check("t4 outstanding 0",   32'(outstanding), 32'd0);
    b_resp(2'b00);
    check("t4 unexpected B",    32'(err_sticky),  32'b011);
    check("t4 counter stays 0", 32'(outstanding), 32'd0);
    err_clr = 1'b1;
    neg(1);
    err_clr = 1'b0;
    check("t4 clear",           32'(err_sticky),  32'd0);
    run_burst(32'h6000, 12'h012);
    check("t4 outstanding 1",   32'(outstanding), 32'd1);
    err_clr = 1'b1;
    b_resp(2'b10);
    err_clr = 1'b0;
    check("t4 set beats clear", 32'(err_sticky),  32'b001);
    err_clr = 1'b1;
    neg(1);
    err_clr = 1'b0;

    // Illegal beat size still issues the burst.
    push(32'h7000, 12'h013);
    wait_aw("t5");
    check("t5 awsize", 32'(axi_awsize), 32'd3);
    check("t5 awlen",  32'(axi_awlen),  32'd1);
    check("t5 awaddr", axi_awaddr,      32'h7000);
    check("t5 err",    32'(err_sticky), 32'b100);
    axi_awready = 1'b1;
    neg(1);
    axi_awready = 1'b0;
    check("t5 pkr_start",   32'(pkr_start),   32'd1);
    check("t5 outstanding", 32'(outstanding), 32'd1);
    w_last_hs = 1'b1;
    neg(1);
    w_last_hs = 1'b0;

    // Reset while AWVALID is high, then a clean burst.
    push(32'h8000, 12'h012);
    wait_aw("t6");
    check("t6 outstanding pre", 32'(outstanding), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6 rst awvalid",     32'(axi_awvalid), 32'd0);
    check("t6 rst burst_pop",   32'(burst_pop),   32'd0);
    check("t6 rst pkr_start",   32'(pkr_start),   32'd0);
    check("t6 rst outstanding", 32'(outstanding), 32'd0);
    check("t6 rst err",         32'(err_sticky),  32'd0);
    check("t6 rst busy",        32'(busy),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h9000, 12'h022);
    wait_aw("t6b");
    check("t6b awaddr", axi_awaddr,      32'h9000);
    check("t6b awlen",  32'(axi_awlen),  32'd2);
    check("t6b awsize", 32'(axi_awsize), 32'd2);
    axi_awready = 1'b1;
    neg(1);
    axi_awready = 1'b0;
    check("t6b pkr_start",   32'(pkr_start),   32'd1);
    check("t6b outstanding", 32'(outstanding), 32'd1);
    w_last_hs = 1'b1;
    neg(1);
    w_last_hs = 1'b0;
    b_resp(2'b00);
    check("t6b outstanding B", 32'(outstanding), 32'd0);
    check("t6b busy",          32'(busy),        32'd0);

    neg(2);
    check("pop with FIFO empty", 32'(bad_pop), 32'd0);
    check("total pops",          32'(pop_cnt), 32'd9);
    check("total AW handshakes", 32'(aw_cnt),  32'd8);
    check("total pkr_start",     32'(pkr_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
